exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Multi-cycle sequencing controller for the RV32 core datapath: program counter plus 2R/1W register file with an addi adder.
- Owns the PC.
- Fetches each instruction from instruction memory over a req/gnt/rvalid handshake.
- Decodes the instruction and issues exactly one register-file write strobe per retired addi.
- Halts on ebreak, illegal instruction or fetch timeout.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
FETCH_TIMEOUT, 16, maximum WAIT-state cycles without rvalid before error halt (1..255)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc while imem_req)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
pc  out  32  current program counter
ist  out  32  latched instruction, to datapath
rf_raddr  out  5  rs1 field
rf_waddr  out  5  rd field
rf_wen  out  1  register-file write strobe, one cycle
imm  out  32  sign-extended I-immediate
halted  out  1  sticky halt indicator
err  out  1  sticky error (illegal or timeout)
err_code  out  2  00 none, 01 illegal, 10 timeout
retire_cnt  out  32  retired instruction count

Behaviour:
- Reset (reset==0, async):
  - state=FETCH, pc=RESET_PC, ist=0, retire_cnt=0, timeout counter=0.
  - imem_req=0, rf_wen=0, halted=0, err=0, err_code=00.
  - First imem_req is asserted in the first clock after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Hold both stable until imem_gnt=1; then go to WAIT.
  - imem_rvalid in FETCH is ignored.
- WAIT:
  - imem_req=0; timeout counter increments each cycle.
  - On imem_rvalid: ist<=imem_rdata, clear counter, go to EXEC.
  - If the counter reaches FETCH_TIMEOUT without rvalid: go to HALT with err=1, err_code=10.
  - rvalid in the same cycle the count reaches FETCH_TIMEOUT wins (no error).
- EXEC (exactly one cycle), decode on ist:
  - addi (opcode 0010011, funct3 000):
    - rf_raddr=ist[19:15], rf_waddr=ist[11:7], imm={{20{ist[31]}},ist[31:20]}.
    - rf_wen=1, except rf_wen=0 when rd==0 (x0 never written).
    - pc<=pc+4 (wraps modulo 2^32), retire_cnt+=1, go to FETCH.
  - ebreak (32'h00100073): retire_cnt+=1, pc unchanged, go to HALT, err stays 0.
  - Anything else: no write, pc unchanged, go to HALT with err=1, err_code=01.
- HALT:
  - Terminal: halted=1, imem_req=0, rf_wen=0; all outputs frozen.
  - Exit only through reset.
- Outside EXEC:
  - rf_wen=0.
  - rf_raddr, rf_waddr and imm still reflect ist combinationally.
- Latency: minimum 3 cycles per instruction (gnt on the first FETCH cycle, rvalid on the first WAIT cycle).
- Reset asserted mid-handshake aborts immediately. No pending rvalid is honoured after reset release until a new gnt.
- retire_cnt wraps at 2^32.

Decomposition:
- Shared package `core_pkg` holds:
  - opcode/funct3 constants (OP_IMM, F3_ADDI);
  - the EBREAK encoding;
  - the state enum (FETCH, WAIT, EXEC, HALT);
  - err_code constants.
- One natural sub-module: `imm_decode` (combinational field and sign-extend extraction from ist), reusable by the datapath.

Test Plan:
1. Reset release, memory grants immediately, rvalid next cycle, ist=32'h00500093 (addi x1,x0,5):
   - imem_addr=0x80000000;
   - rf_wen=1 for one cycle with rf_waddr=1, rf_raddr=0, imm=5;
   - pc=0x80000004, retire_cnt=1.
2. addi x0,x0,1 (32'h00100013) → rf_wen stays 0; pc advances by 4; retire_cnt increments.
3. addi x2,x1,-1 (32'hFFF08113) → imm=32'hFFFFFFFF, rf_waddr=2, rf_raddr=1.
4. gnt delayed 3 cycles:
   - imem_req and imem_addr stable for 4 cycles;
   - rvalid asserted while still in FETCH has no effect.
5. rvalid withheld for 16 WAIT cycles → halted=1, err=1, err_code=10; no further imem_req. Repeat with rvalid on exactly the 16th cycle → no error.
6. Two cases, then reset asserted during WAIT:
   - ebreak → halted=1, err=0, retire_cnt+1;
   - 32'h00000033 → halted=1, err_code=01, pc unchanged;
   - reset asserted during WAIT → pc=0x80000000, state FETCH, all strobes 0 asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared RV32 decode constants, controller state and error codes.
package core_pkg;
    localparam logic [6:0]  OP_IMM      = 7'b0010011;
    localparam logic [2:0]  F3_ADDI     = 3'b000;
    localparam logic [31:0] EBREAK      = 32'h00100073;
    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_ILLEGAL = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
    typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational field extraction, I-immediate sign extension and addi/ebreak recognition.
module imm_decode
    import core_pkg::*;
(
    input  logic [31:0] i_ist,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    output logic        o_is_addi,
    output logic        o_is_ebreak
);
    assign o_rs1       = i_ist[19:15];
    assign o_rd        = i_ist[11:7];
    assign o_imm       = {{20{i_ist[31]}}, i_ist[31:20]};
    assign o_is_addi   = (i_ist[6:0] == OP_IMM) && (i_ist[14:12] == F3_ADDI);
    assign o_is_ebreak = (i_ist == EBREAK);
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle fetch/wait/exec sequencer owning the PC; retires addi, halts on ebreak, illegal or fetch timeout.
module exec_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ist,
    output logic [4:0]  rf_raddr,
    output logic [4:0]  rf_waddr,
    output logic        rf_wen,
    output logic [31:0] imm,
    output logic        halted,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] retire_cnt
);
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ist, r_retire;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic        w_addi, w_ebreak, w_last_wait;

    imm_decode u_dec (
        .i_ist       (r_ist),
        .o_rs1       (rf_raddr),
        .o_rd        (rf_waddr),
        .o_imm       (imm),
        .o_is_addi   (w_addi),
        .o_is_ebreak (w_ebreak)
    );

    assign w_last_wait = (r_cnt == 8'(FETCH_TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   w_next = imem_gnt ? WAIT : FETCH;
            WAIT:    w_next = imem_rvalid ? EXEC : (w_last_wait ? HALT : WAIT);
            EXEC:    w_next = w_addi ? FETCH : HALT;
            default: w_next = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_ist      <= '0;
            r_retire   <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT) begin
                r_cnt <= imem_rvalid ? 8'd0 : r_cnt + 8'd1;
                if (imem_rvalid)
                    r_ist <= imem_rdata;
                else if (w_last_wait) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                end
            end
            if (r_state == EXEC) begin
                if (w_addi)
                    r_pc <= r_pc + 32'd4;
                if (w_addi || w_ebreak)
                    r_retire <= r_retire + 32'd1;
                else begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_ILLEGAL;
                end
            end
        end
    end

    // reset gates the request so it stays low while reset is held
    assign imem_req   = reset && (r_state == FETCH);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign ist        = r_ist;
    assign rf_wen     = (r_state == EXEC) && w_addi && (rf_waddr != 5'd0);
    assign halted     = (r_state == HALT);
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign retire_cnt = r_retire;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized programs run against an instruction-level model; fetches and writes checked through scoreboard queues.
module tb_exec_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] pc, ist, imm, retire_cnt;
    logic [4:0]  rf_raddr, rf_waddr;
    logic        rf_wen, halted, err;
    logic [1:0]  err_code;

    int n_tot = 0, n_pass = 0;
    logic [31:0] q_f[$];
    logic [73:0] q_w[$];
    logic [31:0] prog[16];
    int          gdly[16], rdly[16];
    bit          spur[16];
    int          to_idx;
    logic [31:0] e_pc, e_cnt, e_ist;
    logic [1:0]  e_code;
    int          n_f;
    bit          hold = 0;
    logic [31:0] hold_addr;

    exec_ctrl dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .ist(ist), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_wen(rf_wen),
        .imm(imm), .halted(halted), .err(err), .err_code(err_code), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (hold) chk("req_stable", {imem_req, imem_addr}, {1'b1, hold_addr});
            hold = imem_req && !imem_gnt;
            hold_addr = imem_addr;
            if (imem_req && imem_gnt) begin
                chk("fetch_pending", 128'(q_f.size() > 0), 1);
                if (q_f.size() > 0) chk("fetch_addr", imem_addr, q_f.pop_front());
            end
            if (rf_wen) begin
                chk("write_pending", 128'(q_w.size() > 0), 1);
                if (q_w.size() > 0) chk("write_fields", {pc, rf_waddr, rf_raddr, imm}, q_w.pop_front());
            end
            if (halted) chk("halt_quiet", {imem_req, rf_wen}, 0);
        end else hold = 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h80000000);
        chk("rst_strobes", {imem_req, rf_wen, halted, err, err_code}, 0);
        chk("rst_cnt_ist", {retire_cnt, ist}, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // instruction-level semantics: walk the straight-line program from the reset PC
    task automatic model;
        logic [31:0] w, p;
        p = 32'h80000000;
        e_cnt = 0;
        e_code = 2'b00;
        n_f = 0;
        for (int k = 0; k < 16; k++) begin
            q_f.push_back(p);
            n_f++;
            if (k == to_idx) begin e_code = 2'b10; break; end
            w = prog[k];
            e_ist = w;
            if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
                if (w[11:7] != 0) q_w.push_back({p, w[11:7], w[19:15], 32'($signed(w[31:20]))});
                p = p + 4;
                e_cnt++;
            end else if (w == 32'h00100073) begin
                e_cnt++;
                break;
            end else begin
                e_code = 2'b01;
                break;
            end
        end
        e_pc = p;
    endtask

    task automatic do_fetch(input int gd, input int rd, input bit sp, input logic [31:0] w, input bit to);
        int t = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        chk("req_seen", imem_req, 1);
        if (!imem_req) return;
        repeat (gd) begin
            imem_gnt = 0; imem_rvalid = sp; imem_rdata = $urandom;
            tick();
        end
        imem_gnt = 1; imem_rvalid = sp; imem_rdata = $urandom;
        tick();
        imem_gnt = 0; imem_rvalid = 0;
        if (to) begin repeat (16) tick(); return; end
        repeat (rd) tick();
        imem_rvalid = 1; imem_rdata = w;
        tick();
        imem_rvalid = 0; imem_rdata = $urandom;
        tick();
    endtask

    task automatic run_prog(input string tag);
        reset_dut();
        model();
        for (int k = 0; k < n_f; k++) do_fetch(gdly[k], rdly[k], spur[k], prog[k], k == to_idx);
        repeat (3) tick();
        chk({tag, "_halt"}, {halted, err, err_code}, {1'b1, e_code != 2'b00, e_code});
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_retire"}, retire_cnt, e_cnt);
        if (e_code != 2'b10) chk({tag, "_ist"}, ist, e_ist);
        chk({tag, "_queues"}, {q_f.size(), q_w.size()}, 0);
        q_f.delete();
        q_w.delete();
    endtask

    task automatic clear_prog;
        for (int k = 0; k < 16; k++) begin
            prog[k] = 32'h00100073; gdly[k] = 0; rdly[k] = 0; spur[k] = 0;
        end
        to_idx = -1;
        e_ist = 0;
    endtask

    function automatic logic [31:0] rand_addi;
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 3) == 0) w[11:7] = 0;
        return {w[31:15], 3'b000, w[11:7], 7'h13};
    endfunction

    initial begin
        tick();
        clear_prog();
        prog[0] = 32'h00500093; prog[1] = 32'h00100013; prog[2] = 32'hFFF08113;
        gdly[3] = 3; spur[3] = 1;
        run_prog("addi_seq");
        clear_prog();
        prog[0] = 32'h00000033;
        run_prog("illegal");
        clear_prog();
        prog[0] = 32'h00500093; to_idx = 1;
        run_prog("timeout");
        clear_prog();
        rdly[0] = 15;
        run_prog("rvalid_16th");

        clear_prog();
        reset_dut();
        q_f.push_back(32'h80000000);
        while (!imem_req) tick();
        imem_gnt = 1;
        tick();
        imem_gnt = 0;
        tick();
        #2;
        reset = 0;
        #1;
        chk("midwait_pc", pc, 32'h80000000);
        chk("midwait_strobes", {imem_req, rf_wen, halted, err}, 0);
        imem_rvalid = 1; imem_rdata = 32'h00500093;
        tick();
        reset = 1;
        tick();
        tick();
        chk("midwait_fetch", {imem_req, imem_addr}, {1'b1, 32'h80000000});
        imem_rvalid = 0;
        q_f.push_back(32'h80000000);
        do_fetch(0, 0, 0, 32'h00100073, 0);
        repeat (2) tick();
        chk("midwait_end", {halted, err, retire_cnt, pc}, {1'b1, 1'b0, 32'd1, 32'h80000000});
        chk("midwait_queues", {q_f.size(), q_w.size()}, 0);
        q_f.delete();
        q_w.delete();

        for (int r = 0; r < 24; r++) begin
            int len;
            clear_prog();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len - 1; k++) prog[k] = rand_addi();
            case ($urandom_range(0, 2))
                0: prog[len-1] = 32'h00100073;
                1: prog[len-1] = {$urandom_range(0, 127) << 25 | ($urandom & 32'h01FFFF80)} | 32'h33;
                default: prog[len-1] = ($urandom & 32'hFFFF8F80) | (32'($urandom_range(1, 7)) << 12) | 32'h13;
            endcase
            for (int k = 0; k < len; k++) begin
                gdly[k] = $urandom_range(0, 3);
                rdly[k] = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
                spur[k] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) to_idx = $urandom_range(0, len - 1);
            run_prog("rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
